// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: bundle of the signals between a PRBS/BIST source side and
// the lfsr_checker receive side.
//   in_valid  - in_bit is sampled on this edge (tie to the lfsr advance)
//   in_bit    - received serial bit
//   taps      - feedback taps, same encoding as the upstream lfsr
//   clear     - zero the bit/error counters
//   locked    - checker is synchronised
//   err_pulse - one-cycle pulse per counted mismatch
//   bit_count - bits checked while locked (saturating)
//   err_count - mismatches while locked (saturating)
// master: the side that feeds bits and reads status; slave: the checker.
interface lfsr_checker_if #(
  parameter int WIDTH     = 5,
  parameter int CNT_WIDTH = 16
) ();
  logic                 in_valid;
  logic                 in_bit;
  logic [WIDTH-1:0]     taps;
  logic                 clear;
  logic                 locked;
  logic                 err_pulse;
  logic [CNT_WIDTH-1:0] bit_count;
  logic [CNT_WIDTH-1:0] err_count;

  modport master (
    output in_valid, in_bit, taps, clear,
    input  locked, err_pulse, bit_count, err_count
  );

  modport slave (
    input  in_valid, in_bit, taps, clear,
    output locked, err_pulse, bit_count, err_count
  );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising receive checker for a Fibonacci LFSR
// stream b[n+1] = ^(taps & {b[n-WIDTH+1] .. b[n]}). Seeds its history from
// the stream, hunts for LOCK_COUNT consecutive correct predictions, then
// free-runs a local reference and counts bits and bit errors.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, highest priority
//   bus  - lfsr_checker_if.slave (in_valid, in_bit, taps, clear in;
//          locked, err_pulse, bit_count, err_count out, all registered)
//
// state  | meaning
// SEED   | filling rx_hist with the first WIDTH bits, no comparison
// HUNT   | predicting from rx_hist, counting consecutive matches
// LOCKED | predicting from the free-running reference, counting errors
module lfsr_checker #(
  parameter int WIDTH       = 5,
  parameter int CNT_WIDTH   = 16,
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_ERRS = 4
) (
  input logic          clk,
  input logic          rst,
  lfsr_checker_if.slave bus
);

  typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_t;

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_LAST   = FILL_W'(WIDTH - 1);
  localparam logic [7:0]        LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [7:0]        UNLOCK_LAST = 8'(UNLOCK_ERRS - 1);

  state_t               state;
  logic [FILL_W-1:0]    fill_cnt;
  logic [7:0]           match_cnt;
  logic [7:0]           miss_cnt;
  logic [WIDTH-1:0]     rx_hist;
  logic [WIDTH-1:0]     ref_state;
  logic                 locked_r;
  logic                 err_pulse_r;
  logic [CNT_WIDTH-1:0] bit_count_r;
  logic [CNT_WIDTH-1:0] err_count_r;

  logic [WIDTH-1:0] hist_sel;
  logic [WIDTH-1:0] rx_next;
  logic             pred;
  logic             mismatch;
  logic             bit_sat;
  logic             err_sat;

  // While locked the prediction comes from our own reference so that a
  // corrupted received bit never pollutes later predictions.
  always_comb begin
    hist_sel = (state == LOCKED) ? ref_state : rx_hist;
    pred     = ^(bus.taps & hist_sel);
    rx_next  = {rx_hist[WIDTH-2:0], bus.in_bit};
    mismatch = (bus.in_bit != pred);
    bit_sat  = &bit_count_r;
    err_sat  = &err_count_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEED;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      rx_hist     <= '0;
      ref_state   <= '0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      bit_count_r <= '0;
      err_count_r <= '0;
    end else begin
      err_pulse_r <= 1'b0;
      if (bus.in_valid) begin
        rx_hist <= rx_next;
        case (state)
          SEED: begin
            if (fill_cnt == FILL_LAST) begin
              state <= HUNT;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          HUNT: begin
            // An all-zero history predicts 0 forever; refuse to count it.
            if (!mismatch && (rx_hist != '0)) begin
              if (match_cnt == LOCK_LAST) begin
                state     <= LOCKED;
                locked_r  <= 1'b1;
                match_cnt <= '0;
                ref_state <= rx_next;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            ref_state <= {ref_state[WIDTH-2:0], pred};
            if (!bus.clear && !bit_sat) begin
              bit_count_r <= bit_count_r + 1'b1;
            end
            if (mismatch) begin
              // A bit swallowed by clear is not counted, so no pulse either.
              if (!bus.clear) begin
                err_pulse_r <= 1'b1;
                if (!err_sat) begin
                  err_count_r <= err_count_r + 1'b1;
                end
              end
              if (miss_cnt == UNLOCK_LAST) begin
                state     <= HUNT;
                locked_r  <= 1'b0;
                miss_cnt  <= '0;
                match_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state <= SEED;
          end
        endcase
      end
      if (bus.clear) begin
        bit_count_r <= '0;
        err_count_r <= '0;
      end
    end
  end

  assign bus.locked    = locked_r;
  assign bus.err_pulse = err_pulse_r;
  assign bus.bit_count = bit_count_r;
  assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: two checkers (16-bit and 4-bit counters) fed the same
// stream. A queue-based reference model pushes the expected registered
// outputs per clock; a monitor pops and compares after each rising edge.
module tb_lfsr_checker;
  localparam int W = 5;
  localparam int LOCK_N = 8;
  localparam int UNLOCK_N = 4;
  localparam int M_SEED = 0, M_HUNT = 1, M_LOCKED = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_bit, clear;
  logic [W-1:0] taps;

  lfsr_checker_if #(.WIDTH(W), .CNT_WIDTH(16)) bus0 ();
  lfsr_checker_if #(.WIDTH(W), .CNT_WIDTH(4))  bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.in_bit   = in_bit;
  assign bus0.taps     = taps;
  assign bus0.clear    = clear;
  assign bus1.in_valid = in_valid;
  assign bus1.in_bit   = in_bit;
  assign bus1.taps     = taps;
  assign bus1.clear    = clear;

  lfsr_checker #(.WIDTH(W), .CNT_WIDTH(16), .LOCK_COUNT(LOCK_N), .UNLOCK_ERRS(UNLOCK_N))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  lfsr_checker #(.WIDTH(W), .CNT_WIDTH(4), .LOCK_COUNT(LOCK_N), .UNLOCK_ERRS(UNLOCK_N))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    bit locked;
    bit ep;
    int bc0, ec0, bc1, ec1;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // ---------------- reference model ----------------
  bit hist[$];   // received bits, newest at the back, always W long
  bit refq[$];   // local reference bits while locked
  int mode, fill, match, miss;
  int bc[2], ec[2];
  int cmax[2] = '{65535, 15};

  function automatic bit predict(input bit use_ref, input logic [W-1:0] t);
    bit x = 0;
    for (int i = 0; i < W; i++) begin
      if (t[i]) x ^= use_ref ? refq[refq.size()-1-i] : hist[hist.size()-1-i];
    end
    return x;
  endfunction

  task automatic model_step(input bit r, input bit v, input bit b, input bit c,
                            input logic [W-1:0] t);
    bit ep = 0;
    bit p, nz, lock_now;
    exp_t e;
    lock_now = 0;
    if (r) begin
      mode = M_SEED; fill = 0; match = 0; miss = 0;
      hist = {}; refq = {};
      for (int i = 0; i < W; i++) begin hist.push_back(0); refq.push_back(0); end
      for (int k = 0; k < 2; k++) begin bc[k] = 0; ec[k] = 0; end
    end else begin
      if (v) begin
        if (mode == M_SEED) begin
          fill++;
          if (fill == W) mode = M_HUNT;
        end else if (mode == M_HUNT) begin
          p = predict(0, t);
          nz = 0;
          foreach (hist[i]) if (hist[i]) nz = 1;
          if (b == p && nz) begin
            match++;
            if (match == LOCK_N) begin mode = M_LOCKED; match = 0; lock_now = 1; end
          end else begin
            match = 0;
          end
        end else begin
          p = predict(1, t);
          refq.push_back(p);
          void'(refq.pop_front());
          for (int k = 0; k < 2; k++) if (!c && bc[k] < cmax[k]) bc[k]++;
          if (b != p) begin
            if (!c) begin
              ep = 1;
              for (int k = 0; k < 2; k++) if (ec[k] < cmax[k]) ec[k]++;
            end
            miss++;
            if (miss == UNLOCK_N) begin mode = M_HUNT; miss = 0; match = 0; end
          end else begin
            miss = 0;
          end
        end
        hist.push_back(b);
        void'(hist.pop_front());
        if (lock_now) refq = hist;
      end
      if (c) for (int k = 0; k < 2; k++) begin bc[k] = 0; ec[k] = 0; end
    end
    e.locked = (mode == M_LOCKED);
    e.ep  = ep;
    e.bc0 = bc[0]; e.ec0 = ec[0];
    e.bc1 = bc[1]; e.ec1 = ec[1];
    expq.push_back(e);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("locked0",    int'(bus0.locked),    int'(e.locked));
        chk("err_pulse0", int'(bus0.err_pulse), int'(e.ep));
        chk("bit_count0", int'(bus0.bit_count), e.bc0);
        chk("err_count0", int'(bus0.err_count), e.ec0);
        chk("locked1",    int'(bus1.locked),    int'(e.locked));
        chk("err_pulse1", int'(bus1.err_pulse), int'(e.ep));
        chk("bit_count1", int'(bus1.bit_count), e.bc1);
        chk("err_count1", int'(bus1.err_count), e.ec1);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] g;

  task automatic gen_bit(output bit o);
    o = ^(taps & g);
    g = {g[W-2:0], o};
  endtask

  task automatic cycle(input bit r, input bit v, input bit b, input bit c);
    rst = r; in_valid = v; in_bit = b; clear = c;
    model_step(r, v, b, c, taps);
    @(negedge clk);
  endtask

  task automatic send(input int n, input bit flip);
    bit o;
    for (int i = 0; i < n; i++) begin
      gen_bit(o);
      cycle(0, 1, o ^ flip, 0);
    end
  endtask

  initial begin
    bit o, v, err, c;
    taps = 5'b10100;
    g = 5'b00001;
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 1);
    send(113, 0);            // lock after 13, then 100 clean bits
    send(1, 1);              // single channel error
    send(30, 0);
    send(4, 1);              // burst that drops lock
    send(40, 0);             // relock
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 200; i++) cycle(0, 1, 0, 0);   // all-zero stream
    cycle(1, 0, 0, 0);
    g = 5'b00001;
    for (int i = 0; i < 300; i++) begin
      v = $urandom_range(0, 1);
      if (v) begin gen_bit(o); cycle(0, 1, o, 0); end
      else cycle(0, 0, 1'($urandom_range(0, 1)), 0);
    end
    send(20, 0);             // saturate the 4-bit counters' bit_count
    gen_bit(o);
    cycle(0, 1, o, 1);       // clear wins over a valid bit
    send(1, 0);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700)  taps = 5'b10010;
      if (i == 1100) taps = 5'b10100;
      v   = ($urandom_range(0, 3) != 0);
      err = ($urandom_range(0, 39) == 0);
      c   = ($urandom_range(0, 99) == 0);
      if (v) begin gen_bit(o); cycle(0, 1, o ^ err, c); end
      else cycle(0, 0, 1'($urandom_range(0, 1)), c);
    end
    send(20, 0);
    gen_bit(o);
    cycle(1, 1, o, 1);       // reset while locked
    send(30, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(posedge clk);
    #3;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: actual=%0d pending required=0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
